gpu_bus_writer: RTL



---
 rtl/gpu_bus_pkg.sv | 22 ++
 rtl/gpu_char_fifo.sv | 49 ++++
 rtl/gpu_bus_writer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gpu_bus_pkg.sv
// Shared constants and FSM state type for the GPU bus writer.
// Optional feature macro: GPU_BUS_WRITER_CRLF_EN (adds the CR_INSERT state).
package gpu_bus_pkg;

  localparam logic [6:0] CODE_LF    = 7'h0A;
  localparam logic [6:0] CODE_CR    = 7'h0D;
  localparam logic [6:0] CODE_CLEAR = 7'h7F;

  // 80x60 clear plus two cycles of margin
  localparam int unsigned CLEAR_CYCLES_DEF = 4802;

`ifdef GPU_BUS_WRITER_CRLF_EN
  typedef enum logic [2:0] {StIdle, StStrobe, StGap, StClearWait, StCrInsert} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStrobe, StGap, StClearWait} state_e;
`endif

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpu_char_fifo.sv
// Synchronous character FIFO; pointers carry an extra wrap bit to tell full from empty.
module gpu_char_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 7
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Writes while full are dropped; the stored entries are never overwritten
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/gpu_bus_writer.sv
// Drains a character FIFO into paced CE/RW/DATA write strobes for the text-mode GPU.
// Optional feature macro: GPU_BUS_WRITER_CRLF_EN (inserts a CR strobe after every LF).
module gpu_bus_writer
  import gpu_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [6:0]                    CHAR_IN,
  input  logic                          CHAR_VALID,
  output logic                          CHAR_READY,
  output logic                          CE,
  output logic                          RW,
  output logic [6:0]                    DATA,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int unsigned CntMax = max_u(CLEAR_CYCLES, GAP_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_ce, w_ce_next;
  logic            r_rw, w_rw_next;
  logic [6:0]      r_data, w_data_next;
  logic            w_launch;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [6:0]      w_fifo_data;

  gpu_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_push  (CHAR_VALID),
    .i_wdata (CHAR_IN),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ce_next    = 1'b1;
    w_rw_next    = 1'b1;
    w_data_next  = r_data;
    w_launch     = 1'b0;
    w_pop        = 1'b0;

    unique case (r_state)
      StIdle: w_launch = 1'b1;
      StStrobe: begin
        if (r_data == CODE_CLEAR) begin
          w_state_next = StClearWait;
          w_cnt_next   = CntW'(CLEAR_CYCLES);
        end else begin
          w_state_next = StGap;
          w_cnt_next   = CntW'(GAP_CYCLES);
        end
      end
      StGap, StClearWait: begin
        if (r_cnt > CntW'(1)) begin
          w_cnt_next = r_cnt - CntW'(1);
        end else begin
`ifdef GPU_BUS_WRITER_CRLF_EN
          if (r_state == StGap && r_data == CODE_LF) begin
            w_state_next = StCrInsert;
            w_ce_next    = 1'b0;
            w_rw_next    = 1'b0;
            w_data_next  = CODE_CR;
          end else begin
            w_state_next = StIdle;
            w_launch     = 1'b1;
          end
`else
          w_state_next = StIdle;
          w_launch     = 1'b1;
`endif
        end
      end
`ifdef GPU_BUS_WRITER_CRLF_EN
      StCrInsert: begin
        w_state_next = StGap;
        w_cnt_next   = CntW'(GAP_CYCLES);
      end
`endif
      default: w_state_next = StIdle;
    endcase

    // End of a gap goes straight into the next strobe, keeping the period at 1+GAP_CYCLES
    if (w_launch && !w_empty) begin
      w_pop        = 1'b1;
      w_state_next = StStrobe;
      w_ce_next    = 1'b0;
      w_rw_next    = 1'b0;
      w_data_next  = w_fifo_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ce    <= 1'b1;
      r_rw    <= 1'b1;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ce    <= w_ce_next;
      r_rw    <= w_rw_next;
      r_data  <= w_data_next;
    end
  end

  assign CE         = r_ce;
  assign RW         = r_rw;
  assign DATA       = r_data;
  assign CHAR_READY = !w_full;
  assign BUSY       = !w_empty || (r_state != StIdle);

endmodule
